// File: rtl/fir_out_requant_fifo_if.sv
// Bus bundle between the FIR output requantizer/FIFO and its neighbours.
// The upstream strobe, downstream handshake and status flags are grouped here.
// Build macro FIR_OUT_SATCNT_EN adds the saturation counter signals.
interface fir_out_requant_fifo_if #(
  parameter int DIN_W  = 22,
  parameter int DOUT_W = 12,
  parameter int AW     = 2
);
  logic [DIN_W-1:0]  din;         // two's complement Q22.18
  logic              din_valid;
  logic [DOUT_W-1:0] dout;        // two's complement Q12.10
  logic              dout_valid;
  logic              dout_ready;
  logic [AW:0]       fifo_count;
  logic              clip;
  logic              overflow;
`ifdef FIR_OUT_SATCNT_EN
  logic              sat_clr;
  logic [7:0]        sat_count;
`endif

  // Environment side: drives samples in and the consumer ready.
  modport master (
    output din, din_valid, dout_ready,
`ifdef FIR_OUT_SATCNT_EN
    output sat_clr,
    input  sat_count,
`endif
    input  dout, dout_valid, fifo_count, clip, overflow
  );

  // Block side: the requantizer/FIFO itself.
  modport slave (
    input  din, din_valid, dout_ready,
`ifdef FIR_OUT_SATCNT_EN
    input  sat_clr,
    output sat_count,
`endif
    output dout, dout_valid, fifo_count, clip, overflow
  );
endinterface

// File: rtl/fir_out_requant_fifo.sv
// FIR output stage: round-half-up and saturate Q22.18 to Q12.10, then buffer
// in a small first-word-fall-through FIFO with a valid/ready read side.
// Optional macro FIR_OUT_SATCNT_EN adds an 8-bit saturating clip counter
// (sat_count) with a clear input (sat_clr).
module fir_out_requant_fifo #(
  parameter int DIN_W  = 22,
  parameter int DOUT_W = 12,
  parameter int SHIFT  = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic clk100,
  input  logic reset,
  fir_out_requant_fifo_if.slave bus
);

  // Rounded value keeps one extra bit so the +1 of rounding cannot wrap.
  localparam int RW = DIN_W - SHIFT + 1;
  localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (DOUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (DOUT_W - 1)));
  localparam logic [AW:0]          FULL_CNT = (AW + 1)'(DEPTH);

  // Requant stage state
  logic [DOUT_W-1:0] q_data_reg;
  logic              q_valid_reg;
  logic              clip_reg;

  // FIFO state
  logic [DOUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              overflow_reg;

  // Combinational requant and handshake decode
  logic signed [RW-1:0] r_wide;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [DOUT_W-1:0]    q_data_next;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 rd_fire;
  logic                 wr_fire;
  logic                 drop;
  logic [AW:0]          count_next;
  logic                 unused_din_lsbs;

  // Bits below the rounding bit only matter through the floor shift.
  assign unused_din_lsbs = ^bus.din[SHIFT-2:0];

  // Floor shift plus the first dropped bit gives round-half-up; then clamp.
  always_comb begin
    r_wide = $signed({bus.din[DIN_W-1], bus.din[DIN_W-1:SHIFT]})
           + $signed({{(RW-1){1'b0}}, bus.din[SHIFT-1]});
    sat_hi = (r_wide > SAT_MAX);
    sat_lo = (r_wide < SAT_MIN);
    if (sat_hi) begin
      q_data_next = SAT_MAX[DOUT_W-1:0];
    end else if (sat_lo) begin
      q_data_next = SAT_MIN[DOUT_W-1:0];
    end else begin
      q_data_next = r_wide[DOUT_W-1:0];
    end
  end

  // A full FIFO still takes a write when the head leaves in the same cycle.
  always_comb begin
    fifo_full  = (count_reg == FULL_CNT);
    fifo_empty = (count_reg == '0);
    rd_fire    = !fifo_empty && bus.dout_ready;
    wr_fire    = q_valid_reg && (!fifo_full || rd_fire);
    drop       = q_valid_reg && fifo_full && !rd_fire;
    count_next = count_reg + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, rd_fire};
  end

  // Requant register: one sample per strobe, clip flags that sample.
  always_ff @(posedge clk100) begin
    if (reset) begin
      q_valid_reg <= 1'b0;
      clip_reg    <= 1'b0;
      q_data_reg  <= '0;
    end else begin
      q_valid_reg <= bus.din_valid;
      clip_reg    <= bus.din_valid && (sat_hi || sat_lo);
      if (bus.din_valid) begin
        q_data_reg <= q_data_next;
      end
    end
  end

  // FIFO storage: no reset so it maps onto plain RAM.
  always_ff @(posedge clk100) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= q_data_reg;
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk100) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Head of FIFO falls through; forced to zero while empty.
  assign bus.dout       = fifo_empty ? '0 : mem[rd_ptr_reg];
  assign bus.dout_valid = !fifo_empty;
  assign bus.fifo_count = count_reg;
  assign bus.clip       = clip_reg;
  assign bus.overflow   = overflow_reg;

`ifdef FIR_OUT_SATCNT_EN
  logic [7:0] sat_count_reg;

  // Clip counter: clear wins over hold, a coincident clip then counts as one.
  always_ff @(posedge clk100) begin
    if (reset) begin
      sat_count_reg <= '0;
    end else if (clip_reg) begin
      if (bus.sat_clr) begin
        sat_count_reg <= 8'd1;
      end else if (sat_count_reg != 8'hFF) begin
        sat_count_reg <= sat_count_reg + 8'd1;
      end
    end else if (bus.sat_clr) begin
      sat_count_reg <= '0;
    end
  end

  assign bus.sat_count = sat_count_reg;
`endif

endmodule

// File: tb/tb_fir_out_requant_fifo.sv
// Directed bench for fir_out_requant_fifo: reset, rounding, saturation,
// overflow, full-with-read and FIR-cadence traffic. Inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_fir_out_requant_fifo;

  logic clk100;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   max_count;
  int   clip_seen;

  fir_out_requant_fifo_if #(.DIN_W(22), .DOUT_W(12), .AW(2)) bus ();

  fir_out_requant_fifo #(
    .DIN_W(22), .DOUT_W(12), .SHIFT(8), .DEPTH(4), .AW(2)
  ) dut (
    .clk100(clk100),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; on return the sample sits in the requant register.
  task automatic send(input logic [21:0] v);
    bus.din       = v;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  // Send, check clip on the q_valid cycle, then check the FIFO head.
  task automatic send_expect(input string tag, input logic [21:0] v,
                             input logic [11:0] exp_dout, input logic exp_clip);
    send(v);
    chk({tag, "_clip"}, 32'(bus.clip), 32'(exp_clip));
    chk({tag, "_early"}, 32'(bus.dout_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(bus.dout_valid), 32'd1);
    chk({tag, "_dout"}, 32'(bus.dout), 32'(exp_dout));
    $display("txn %s din=0x%06h dout=0x%03h clip=%0d", tag, v, bus.dout, exp_clip);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
`ifdef FIR_OUT_SATCNT_EN
    bus.sat_clr    = 1'b0;
`endif
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("init_count", 32'(bus.fifo_count), 32'd0);
    chk("init_valid", 32'(bus.dout_valid), 32'd0);

    // 1. Reset with 3 stored entries and one still in the requant register
    send(22'h000100);
    send(22'h000200);
    send(22'h000300);
    send(22'h000400);
    chk("pre_rst_count", 32'(bus.fifo_count), 32'd3);
    do_reset();
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_clip", 32'(bus.clip), 32'd0);
    tick();
    chk("rst_inflight", 32'(bus.fifo_count), 32'd0);
    $display("txn reset done");

    // 2. Rounding, 3. saturation
    bus.dout_ready = 1'b1;
    send_expect("rnd_half_pos", 22'h000080, 12'h001, 1'b0);
    send_expect("rnd_m128", 22'h3FFF80, 12'h000, 1'b0);
    send_expect("rnd_m129", 22'h3FFF7F, 12'hFFF, 1'b0);
    send_expect("sat_pos", 22'h1FFFFF, 12'h7FF, 1'b1);
    send_expect("sat_neg", 22'h200000, 12'h800, 1'b1);
    send_expect("nosat_max", 22'h07FF7F, 12'h7FF, 1'b0);
    chk("post_sat_clip", 32'(bus.clip), 32'd0);
    chk("post_sat_count", 32'(bus.fifo_count), 32'd0);

    // 4. Fill with no reader: fifth sample is dropped
    bus.dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(22'(i << 8));
    end
    tick();
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    chk("full_ovf", 32'(bus.overflow), 32'd1);
    bus.dout_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("full_read", 32'(bus.dout), 32'(i));
      $display("txn read %0d dout=0x%03h", i, bus.dout);
      tick();
    end
    chk("drain_valid", 32'(bus.dout_valid), 32'd0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.dout_ready = 1'b0;

    // 5. Full FIFO with a read on the same edge as the incoming write
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(22'((8'h10 + i) << 8));
    end
    tick();
    chk("f5_count", 32'(bus.fifo_count), 32'd4);
    send(22'h002000);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    chk("f5_no_ovf", 32'(bus.overflow), 32'd0);
    chk("f5_count_hold", 32'(bus.fifo_count), 32'd4);
    bus.dout_ready = 1'b1;
    chk("f5_rd0", 32'(bus.dout), 32'h011);
    tick();
    chk("f5_rd1", 32'(bus.dout), 32'h012);
    tick();
    chk("f5_rd2", 32'(bus.dout), 32'h013);
    tick();
    chk("f5_rd3_new", 32'(bus.dout), 32'h020);
    $display("txn full-with-read new sample dout=0x%03h", bus.dout);
    tick();
    chk("f5_empty", 32'(bus.fifo_count), 32'd0);

    // 6. FIR cadence: one strobe per 5 cycles, consumer always ready
    max_count = 0;
    clip_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3 || i == 7 || i == 11) begin
        send(22'h1FFFFF);
      end else begin
        send(22'(i << 8));
      end
      for (int c = 0; c < 5; c++) begin
        if (bus.clip) clip_seen++;
        if (int'(bus.fifo_count) > max_count) max_count = int'(bus.fifo_count);
        if (c < 4) tick();
      end
      $display("txn cadence %0d", i);
    end
    tick();
    chk("cad_max_count", 32'(max_count), 32'd1);
    chk("cad_clips", 32'(clip_seen), 32'd3);
    chk("cad_end_count", 32'(bus.fifo_count), 32'd0);
    chk("cad_no_ovf", 32'(bus.overflow), 32'd0);

`ifdef FIR_OUT_SATCNT_EN
    chk("satcnt_3", 32'(bus.sat_count), 32'd3);
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    chk("satcnt_clr", 32'(bus.sat_count), 32'd0);
    send(22'h200000);
    send(22'h200000);
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    chk("satcnt_clr_clip", 32'(bus.sat_count), 32'd1);
    $display("txn sat_count clear with clip -> %0d", bus.sat_count);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
